// File: rtl/sprite_compositor.sv
// +----------------------------------------------------------------------------+
// | sprite_compositor                                                          |
// | Merges NUM_LAYERS widget pixels over a background colour with priority or  |
// | saturating-add blending, plus per-frame layer collision flags.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module sprite_compositor #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W    = 4,
  parameter int BLEND_MODE = 0,
  parameter int FCNT_W     = 16
) (
  input  logic                          CLK_100MHz,
  input  logic                          Reset,
  input  logic                          HBlank,
  input  logic                          VBlank,
  input  logic [NUM_LAYERS-1:0]         layerYes,
  input  logic [NUM_LAYERS-1:0]         layerEnable,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layerRed,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layerGreen,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layerBlue,
  input  logic [COLOR_W-1:0]            bgRed,
  input  logic [COLOR_W-1:0]            bgGreen,
  input  logic [COLOR_W-1:0]            bgBlue,
  output logic [COLOR_W-1:0]            RED,
  output logic [COLOR_W-1:0]            GREEN,
  output logic [COLOR_W-1:0]            BLUE,
  output logic                          HBlankOut,
  output logic                          VBlankOut,
  output logic [NUM_LAYERS-1:0]         collide,
  output logic                          frameDone,
  output logic [FCNT_W-1:0]             frameCount
);

  localparam int                SUM_W     = COLOR_W + $clog2(NUM_LAYERS);
  localparam logic [SUM_W-1:0]  C_SAT_MAX = SUM_W'({COLOR_W{1'b1}});

  logic [NUM_LAYERS-1:0]         vis_s1;
  logic [NUM_LAYERS*COLOR_W-1:0] red_s1, green_s1, blue_s1;
  logic [COLOR_W-1:0]            bg_red_s1, bg_green_s1, bg_blue_s1;
  logic                          hblank_s1, vblank_s1;

  logic                          active_s1;
  logic                          overlap_s1;
  logic                          frame_edge;
  logic [SUM_W-1:0]              sum_red, sum_green, sum_blue;
  logic [COLOR_W-1:0]            red_nxt, green_nxt, blue_nxt;
  logic [NUM_LAYERS-1:0]         acc;

  always_ff @(posedge CLK_100MHz or negedge Reset) begin
    if (!Reset) begin
      vis_s1      <= '0;
      red_s1      <= '0;
      green_s1    <= '0;
      blue_s1     <= '0;
      bg_red_s1   <= '0;
      bg_green_s1 <= '0;
      bg_blue_s1  <= '0;
      hblank_s1   <= 1'b0;
      vblank_s1   <= 1'b0;
    end else begin
      vis_s1      <= layerYes & layerEnable;
      red_s1      <= layerRed;
      green_s1    <= layerGreen;
      blue_s1     <= layerBlue;
      bg_red_s1   <= bgRed;
      bg_green_s1 <= bgGreen;
      bg_blue_s1  <= bgBlue;
      hblank_s1   <= HBlank;
      vblank_s1   <= VBlank;
    end
  end

  assign active_s1  = ~hblank_s1 & ~vblank_s1;
  // Clearing the lowest set bit leaves something only when two or more layers are visible.
  assign overlap_s1 = (vis_s1 & (vis_s1 - NUM_LAYERS'(1))) != '0;
  assign frame_edge = vblank_s1 & ~VBlankOut;

  always_comb begin
    sum_red   = '0;
    sum_green = '0;
    sum_blue  = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (vis_s1[i]) begin
        sum_red   = sum_red   + SUM_W'(red_s1[i*COLOR_W +: COLOR_W]);
        sum_green = sum_green + SUM_W'(green_s1[i*COLOR_W +: COLOR_W]);
        sum_blue  = sum_blue  + SUM_W'(blue_s1[i*COLOR_W +: COLOR_W]);
      end
    end
  end

  always_comb begin
    red_nxt   = '0;
    green_nxt = '0;
    blue_nxt  = '0;
    if (!active_s1) begin
      red_nxt   = '0;
      green_nxt = '0;
      blue_nxt  = '0;
    end else if (vis_s1 == '0) begin
      red_nxt   = bg_red_s1;
      green_nxt = bg_green_s1;
      blue_nxt  = bg_blue_s1;
    end else if (BLEND_MODE == 0) begin
      // Walk from the top index down so the lowest visible index is written last.
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
        if (vis_s1[i]) begin
          red_nxt   = red_s1[i*COLOR_W +: COLOR_W];
          green_nxt = green_s1[i*COLOR_W +: COLOR_W];
          blue_nxt  = blue_s1[i*COLOR_W +: COLOR_W];
        end
      end
    end else begin
      red_nxt   = (sum_red   > C_SAT_MAX) ? '1 : sum_red[COLOR_W-1:0];
      green_nxt = (sum_green > C_SAT_MAX) ? '1 : sum_green[COLOR_W-1:0];
      blue_nxt  = (sum_blue  > C_SAT_MAX) ? '1 : sum_blue[COLOR_W-1:0];
    end
  end

  always_ff @(posedge CLK_100MHz or negedge Reset) begin
    if (!Reset) begin
      RED       <= '0;
      GREEN     <= '0;
      BLUE      <= '0;
      HBlankOut <= 1'b0;
      VBlankOut <= 1'b0;
    end else begin
      RED       <= red_nxt;
      GREEN     <= green_nxt;
      BLUE      <= blue_nxt;
      HBlankOut <= hblank_s1;
      VBlankOut <= vblank_s1;
    end
  end

  always_ff @(posedge CLK_100MHz or negedge Reset) begin
    if (!Reset) begin
      acc        <= '0;
      collide    <= '0;
      frameDone  <= 1'b0;
      frameCount <= '0;
    end else begin
      frameDone <= frame_edge;
      if (frame_edge) begin
        collide    <= acc;
        acc        <= '0;
        frameCount <= frameCount + FCNT_W'(1);
      end else if (active_s1 && overlap_s1) begin
        acc <= acc | vis_s1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: a priority DUT and an additive DUT share one
// stimulus stream and are compared against a pixel/frame reference model.
`default_nettype none

module tb_sprite_compositor;

  typedef struct packed {
    logic        hb;
    logic        vb;
    logic [3:0]  yes;
    logic [3:0]  en;
    logic [15:0] r;
    logic [15:0] g;
    logic [15:0] b;
    logic [3:0]  bgr;
    logic [3:0]  bgg;
    logic [3:0]  bgb;
  } pix_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  pix_t cur = '0;

  always #5 clk = ~clk;

  logic [3:0]  red0, green0, blue0, col0, red1, green1, blue1, col1;
  logic        hbo0, vbo0, fd0, hbo1, vbo1, fd1;
  logic [1:0]  fc0;
  logic [15:0] fc1;

  sprite_compositor #(.NUM_LAYERS(4), .COLOR_W(4), .BLEND_MODE(0), .FCNT_W(2)) dut0 (
    .CLK_100MHz(clk), .Reset(rst_n), .HBlank(cur.hb), .VBlank(cur.vb),
    .layerYes(cur.yes), .layerEnable(cur.en),
    .layerRed(cur.r), .layerGreen(cur.g), .layerBlue(cur.b),
    .bgRed(cur.bgr), .bgGreen(cur.bgg), .bgBlue(cur.bgb),
    .RED(red0), .GREEN(green0), .BLUE(blue0), .HBlankOut(hbo0), .VBlankOut(vbo0),
    .collide(col0), .frameDone(fd0), .frameCount(fc0)
  );

  sprite_compositor #(.NUM_LAYERS(4), .COLOR_W(4), .BLEND_MODE(1), .FCNT_W(16)) dut1 (
    .CLK_100MHz(clk), .Reset(rst_n), .HBlank(cur.hb), .VBlank(cur.vb),
    .layerYes(cur.yes), .layerEnable(cur.en),
    .layerRed(cur.r), .layerGreen(cur.g), .layerBlue(cur.b),
    .bgRed(cur.bgr), .bgGreen(cur.bgg), .bgBlue(cur.bgb),
    .RED(red1), .GREEN(green1), .BLUE(blue1), .HBlankOut(hbo1), .VBlankOut(vbo1),
    .collide(col1), .frameDone(fd1), .frameCount(fc1)
  );

  logic [20:0] out0, exp0;
  logic [34:0] out1, exp1;
  assign out0 = {red0, green0, blue0, hbo0, vbo0, col0, fd0, fc0};
  assign out1 = {red1, green1, blue1, hbo1, vbo1, col1, fd1, fc1};

  // Reference model state
  pix_t        p1, p2;
  logic [3:0]  acc_m, col_m;
  logic        fd_m, hbo_m, vbo_m;
  logic [31:0] fc_m;
  logic [11:0] rgb0_m, rgb1_m;
  assign exp0 = {rgb0_m, hbo_m, vbo_m, col_m, fd_m, fc_m[1:0]};
  assign exp1 = {rgb1_m, hbo_m, vbo_m, col_m, fd_m, fc_m[15:0]};

  int tests = 0;
  int fails = 0;

  function automatic logic [11:0] blend(pix_t p, bit add);
    logic [3:0] vis;
    int sr, sg, sb;
    bit found;
    logic [11:0] res;
    vis = p.yes & p.en;
    res = 12'h000;
    found = 1'b0;
    sr = 0; sg = 0; sb = 0;
    if (p.hb || p.vb) begin
      res = 12'h000;
    end else if (vis == 4'b0000) begin
      res = {p.bgr, p.bgg, p.bgb};
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (vis[i]) begin
          sr += int'(p.r[i*4 +: 4]);
          sg += int'(p.g[i*4 +: 4]);
          sb += int'(p.b[i*4 +: 4]);
          if (!found && !add) res = {p.r[i*4 +: 4], p.g[i*4 +: 4], p.b[i*4 +: 4]};
          found = 1'b1;
        end
      end
      if (add) res = {4'((sr > 15) ? 15 : sr), 4'((sg > 15) ? 15 : sg), 4'((sb > 15) ? 15 : sb)};
    end
    return res;
  endfunction

  task automatic model_reset();
    p1 = '0; p2 = '0; acc_m = '0; col_m = '0; fd_m = 1'b0; fc_m = '0;
    rgb0_m = '0; rgb1_m = '0; hbo_m = 1'b0; vbo_m = 1'b0;
  endtask

  // One clock: pixel entering stage 1 last cycle (p1) becomes this cycle's output.
  task automatic tick();
    logic [3:0] vis;
    @(posedge clk);
    vis    = p1.yes & p1.en;
    hbo_m  = p1.hb;
    vbo_m  = p1.vb;
    rgb0_m = blend(p1, 1'b0);
    rgb1_m = blend(p1, 1'b1);
    fd_m   = p1.vb && !p2.vb;
    if (fd_m) begin
      col_m = acc_m;
      acc_m = '0;
      fc_m  = fc_m + 1;
    end else if (!p1.hb && !p1.vb && $countones(vis) >= 2) begin
      acc_m = acc_m | vis;
    end
    p2 = p1;
    p1 = cur;
    #1;
  endtask

  task automatic set_stim(input logic hb, input logic vb, input logic [3:0] yes, input logic [3:0] en);
    cur.hb = hb; cur.vb = vb; cur.yes = yes; cur.en = en;
    cur.r = 16'($urandom); cur.g = 16'($urandom); cur.b = 16'($urandom);
    cur.bgr = 4'($urandom); cur.bgg = 4'($urandom); cur.bgb = 4'($urandom);
  endtask

  // Raster: 8-pixel lines (2 of them blanking), 4 lines per frame (last is vertical blank).
  task automatic raster_stim(input int c, input bit rnd);
    logic [3:0] yes, en;
    yes = rnd ? 4'($urandom) : 4'b0000;
    en  = (rnd && $urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
    set_stim((c % 8) >= 6, ((c / 8) % 4) == 3, yes, en);
  endtask

  task automatic test_reset();
    #12;
    tests++; if (out0 !== '0) begin fails++; $display("FAIL reset_hold dut0 got %h expected 0", out0); end
    tests++; if (out1 !== '0) begin fails++; $display("FAIL reset_hold dut1 got %h expected 0", out1); end
    #10 rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 12; c++) begin
      raster_stim(c, 1'b1);
      tick();
      tests++; if (out0 !== exp0) begin fails++; $display("FAIL reset_run c%0d dut0 got %h expected %h", c, out0, exp0); end
      tests++; if (out1 !== exp1) begin fails++; $display("FAIL reset_run c%0d dut1 got %h expected %h", c, out1, exp1); end
    end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (out0 !== '0) begin fails++; $display("FAIL reset_mid dut0 got %h expected 0", out0); end
    tests++; if (out1 !== '0) begin fails++; $display("FAIL reset_mid dut1 got %h expected 0", out1); end
    model_reset();
    #2 rst_n = 1'b1;
    for (int c = 0; c < 34; c++) begin
      raster_stim(c, 1'b0);
      tick();
      tests++; if (out0 !== exp0) begin fails++; $display("FAIL reset_frame c%0d dut0 got %h expected %h", c, out0, exp0); end
    end
    tests++; if (fc1 !== 16'd1 || col1 !== 4'b0000) begin
      fails++; $display("FAIL reset_first_frame got count %0d collide %b expected 1 0000", fc1, col1);
    end
  endtask

  task automatic test_priority();
    for (int i = 0; i < 3; i++) begin
      set_stim(1'b0, 1'b0, (i == 0) ? 4'b0110 : 4'b0000, 4'hF);
      if (i == 0) cur.r = 16'h03F0;
      if (i == 1) cur.bgr = 4'h6;
      tick();
      tests++; if (out0 !== exp0) begin fails++; $display("FAIL prio step%0d dut0 got %h expected %h", i, out0, exp0); end
      if (i == 1) begin
        tests++; if (red0 !== 4'd15) begin fails++; $display("FAIL prio_red got %0d expected 15", red0); end
      end
      if (i == 2) begin
        tests++; if (red0 !== 4'h6) begin fails++; $display("FAIL prio_bg got %0d expected 6", red0); end
      end
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 3; i++) begin
      set_stim(1'b0, 1'b0, (i < 2) ? 4'b0011 : 4'b0000, 4'hF);
      if (i == 0) cur.g = 16'h0099;
      if (i == 1) cur.g = 16'h0043;
      tick();
      tests++; if (out1 !== exp1) begin fails++; $display("FAIL sat step%0d dut1 got %h expected %h", i, out1, exp1); end
      if (i == 1) begin
        tests++; if (green1 !== 4'd15) begin fails++; $display("FAIL sat_clamp got %0d expected 15", green1); end
      end
      if (i == 2) begin
        tests++; if (green1 !== 4'd7) begin fails++; $display("FAIL sat_sum got %0d expected 7", green1); end
      end
    end
  endtask

  task automatic test_collision();
    logic [1:0] tv [12]  = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01};
    logic [3:0] ty [12]  = '{4'h0, 4'h0, 4'h0, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0};
    for (int i = 0; i < 12; i++) begin
      set_stim(tv[i][1], tv[i][0], ty[i], 4'hF);
      tick();
      tests++; if (out0 !== exp0) begin fails++; $display("FAIL coll step%0d dut0 got %h expected %h", i, out0, exp0); end
      if (i == 6) begin
        tests++; if (col0 !== 4'b1001 || fd0 !== 1'b1) begin
          fails++; $display("FAIL coll_flag got collide %b done %b expected 1001 1", col0, fd0);
        end
      end
      if (i == 7) begin
        tests++; if (col1 !== 4'b1001 || fd1 !== 1'b0) begin
          fails++; $display("FAIL coll_hold got collide %b done %b expected 1001 0", col1, fd1);
        end
      end
      if (i == 11) begin
        tests++; if (col0 !== 4'b0000 || fd0 !== 1'b1) begin
          fails++; $display("FAIL coll_clean got collide %b done %b expected 0000 1", col0, fd0);
        end
      end
    end
  endtask

  task automatic test_blank_disable();
    logic [1:0] tv [7] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01};
    logic [3:0] ty [7] = '{4'h0, 4'h0, 4'h9, 4'h9, 4'h8, 4'h0, 4'h0};
    logic [3:0] te [7] = '{4'hF, 4'hF, 4'hF, 4'h7, 4'h7, 4'hF, 4'hF};
    for (int i = 0; i < 7; i++) begin
      set_stim(tv[i][1], tv[i][0], ty[i], te[i]);
      if (i == 4) {cur.bgr, cur.bgg, cur.bgb} = 12'hA5C;
      tick();
      tests++; if (out1 !== exp1) begin fails++; $display("FAIL blank step%0d dut1 got %h expected %h", i, out1, exp1); end
      if (i == 5) begin
        tests++; if ({red0, green0, blue0} !== 12'hA5C) begin
          fails++; $display("FAIL disabled_drawn got %h expected a5c", {red0, green0, blue0});
        end
      end
      if (i == 6) begin
        tests++; if (col0 !== 4'b0000 || fd0 !== 1'b1) begin
          fails++; $display("FAIL blank_collide got collide %b done %b expected 0000 1", col0, fd0);
        end
      end
    end
  endtask

  task automatic test_frame_wrap();
    int seq [5] = '{1, 2, 3, 0, 1};
    int nf = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #3 rst_n = 1'b1;
    for (int c = 0; c < 160; c++) begin
      raster_stim(c, 1'b0);
      tick();
      tests++; if (out0 !== exp0) begin fails++; $display("FAIL wrap c%0d dut0 got %h expected %h", c, out0, exp0); end
      if (fd_m && nf < 5) begin
        tests++; if (int'(fc0) != seq[nf]) begin
          fails++; $display("FAIL wrap_count frame%0d got %0d expected %0d", nf, fc0, seq[nf]);
        end
        nf++;
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 256; c++) begin
      raster_stim(c, 1'b1);
      tick();
      tests++; if (out0 !== exp0) begin fails++; $display("FAIL rand c%0d dut0 got %h expected %h", c, out0, exp0); end
      tests++; if (out1 !== exp1) begin fails++; $display("FAIL rand c%0d dut1 got %h expected %h", c, out1, exp1); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_priority();
    test_saturate();
    test_collision();
    test_blank_disable();
    test_frame_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
